// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 16-bit WISC core: owns the PC, fetches one word per
// req/rdy handshake and presents it with its PC until the decoder accepts it.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [15:0]       imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_t;

    state_t            state, state_next;
    logic              req_next;
    logic [ADDR_W-1:0] addr_next;
    logic [15:0]       instr_next;
    logic [ADDR_W-1:0] instr_pc_next;
    logic [ADDR_W-1:0] pc_plus1_next;
    logic              valid_next;
    logic              halted_next;
    logic              pending, pending_next;
    logic [ADDR_W-1:0] pending_pc, pending_pc_next;

    // Wraps modulo 2^ADDR_W; no carry is reported.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_next      = state;
        req_next        = imem_req;
        addr_next       = imem_addr;
        instr_next      = instr;
        instr_pc_next   = instr_pc;
        pc_plus1_next   = pc_plus1;
        valid_next      = instr_valid;
        halted_next     = halted;
        pending_next    = pending;
        pending_pc_next = pending_pc;

        case (state)
            IDLE: begin
                state_next = REQ;
                req_next   = 1'b1;
                addr_next  = RESET_PC;
            end
            REQ: begin
                if (imem_rdy) begin
                    // A redirect seen during this request (or in the rdy cycle) kills the word.
                    if (pending || redirect) begin
                        addr_next    = redirect ? redirect_pc : pending_pc;
                        pending_next = 1'b0;
                    end else begin
                        instr_next    = imem_data;
                        instr_pc_next = imem_addr;
                        pc_plus1_next = pc_inc(imem_addr);
                        valid_next    = 1'b1;
                        req_next      = 1'b0;
                        state_next    = HOLD;
                    end
                end else if (redirect) begin
                    pending_next    = 1'b1;
                    pending_pc_next = redirect_pc;
                end
            end
            HOLD: begin
                if (!stall && halt) begin
                    state_next  = HALTED;
                    valid_next  = 1'b0;
                    req_next    = 1'b0;
                    halted_next = 1'b1;
                end else if (redirect) begin
                    valid_next = 1'b0;
                    addr_next  = redirect_pc;
                    req_next   = 1'b1;
                    state_next = REQ;
                end else if (!stall) begin
                    valid_next = 1'b0;
                    addr_next  = pc_plus1;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            HALTED: begin
                req_next    = 1'b0;
                valid_next  = 1'b0;
                halted_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= 16'h0000;
            instr_pc    <= '0;
            pc_plus1    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            pending     <= 1'b0;
            pending_pc  <= '0;
        end else begin
            state       <= state_next;
            imem_req    <= req_next;
            imem_addr   <= addr_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            pc_plus1    <= pc_plus1_next;
            instr_valid <= valid_next;
            halted      <= halted_next;
            pending     <= pending_next;
            pending_pc  <= pending_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a transaction-level model of the fetch rules.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus1;
    logic        instr_valid;
    logic        halted;

    int n_vec = 0;
    int n_bad = 0;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr(instr), .instr_pc(instr_pc), .pc_plus1(pc_plus1),
        .instr_valid(instr_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what the fetch stage is doing, described as "waiting on a fetch",
    // "presenting a word", "stopped", plus the newest redirect target seen while waiting.
    logic        m_started, m_req, m_valid, m_halted, m_tgt_vld;
    logic [15:0] m_addr, m_instr, m_pc, m_pp1, m_tgt;

    task automatic m_reset();
        m_started = 0; m_req = 0; m_valid = 0; m_halted = 0; m_tgt_vld = 0;
        m_addr = 16'h0000; m_instr = 0; m_pc = 0; m_pp1 = 0; m_tgt = 0;
    endtask

    task automatic m_step();
        if (m_halted) begin
            // stopped for good
        end else if (!m_started) begin
            m_started = 1; m_req = 1; m_addr = 16'h0000;
        end else if (m_req) begin
            if (imem_rdy) begin
                if (m_tgt_vld || redirect) begin
                    m_addr = redirect ? redirect_pc : m_tgt;
                    m_tgt_vld = 0;
                end else begin
                    m_instr = imem_data; m_pc = m_addr; m_pp1 = m_addr + 16'd1;
                    m_valid = 1; m_req = 0;
                end
            end else if (redirect) begin
                m_tgt_vld = 1; m_tgt = redirect_pc;
            end
        end else if (m_valid) begin
            if (!stall && halt) begin
                m_halted = 1; m_valid = 0; m_req = 0;
            end else if (redirect || !stall) begin
                m_addr = redirect ? redirect_pc : m_pc + 16'd1;
                m_valid = 0; m_req = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else m_step();
        #1;
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", instr_valid, m_valid);
        chk("halted", halted, m_halted);
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_pc);
        chk("pc_plus1", pc_plus1, m_pp1);
    end

    // Inputs are applied at a falling edge and held until the next falling edge.
    task automatic drive(input logic rdy, input logic [15:0] data, input logic stl,
                         input logic rd, input logic [15:0] rpc, input logic hlt);
        imem_rdy = rdy; imem_data = data; stall = stl;
        redirect = rd; redirect_pc = rpc; halt = hlt;
        @(negedge clk);
    endtask

    task automatic goto_hold(input logic [15:0] data);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            drive(1, data, 0, 0, 16'h0, 0);
            n++;
        end
        if (!instr_valid) chk("goto_hold_timeout", instr_valid, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_addr"}, imem_addr, 16'h0000);
        chk({tag, "_instr"}, instr, 16'h0000);
        chk({tag, "_pc"}, instr_pc, 16'h0000);
        chk({tag, "_pp1"}, pc_plus1, 16'h0000);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq[$];
        rst_n = 0;
        imem_rdy = 0; imem_data = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1;

        // Zero-wait fetch with PC-valued words
        for (int i = 0; i < 8; i++) begin
            drive(1, imem_addr, 0, 0, 16'h0, 0);
            if (instr_valid) begin
                seq.push_back(instr_pc);
                chk("seq_instr", instr, instr_pc);
                chk("seq_pp1", pc_plus1, instr_pc + 16'd1);
            end
        end
        chk("seq_len", seq.size(), 4);
        for (int k = 0; k < seq.size(); k++) chk("seq_pc", seq[k], k);

        // Wait states at address 5, then stall in HOLD
        drive(0, 16'h0, 0, 1, 16'h0005, 0);
        chk("ws_req", imem_req, 1);
        chk("ws_addr0", imem_addr, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            drive(0, 16'h0, 0, 0, 16'h0, 0);
            chk("ws_addr_held", imem_addr, 16'h0005);
            chk("ws_no_valid", instr_valid, 0);
        end
        drive(1, 16'h1234, 0, 0, 16'h0, 0);
        chk("ws_valid", instr_valid, 1);
        chk("ws_pc", instr_pc, 16'h0005);
        chk("ws_instr", instr, 16'h1234);
        for (int i = 0; i < 2; i++) begin
            drive(1, 16'h9999, 1, 0, 16'h0, 0);
            chk("stall_valid", instr_valid, 1);
            chk("stall_no_req", imem_req, 0);
            chk("stall_pc", instr_pc, 16'h0005);
        end
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        chk("adv_addr", imem_addr, 16'h0006);

        // Redirect in HOLD under stall, then double redirect while waiting
        goto_hold(16'h2222);
        drive(0, 16'h0, 1, 1, 16'h0040, 0);
        chk("rdh_valid", instr_valid, 0);
        chk("rdh_req", imem_req, 1);
        chk("rdh_addr", imem_addr, 16'h0040);
        drive(0, 16'h0, 0, 1, 16'h0010, 0);
        drive(0, 16'h0, 0, 1, 16'h0020, 0);
        chk("rdq_addr_held", imem_addr, 16'h0040);
        drive(1, 16'hBEEF, 0, 0, 16'h0, 0);
        chk("rdq_discard", instr_valid, 0);
        chk("rdq_req", imem_req, 1);
        chk("rdq_addr", imem_addr, 16'h0020);
        drive(1, 16'h3333, 0, 0, 16'h0, 0);
        chk("rdq_pc", instr_pc, 16'h0020);
        chk("rdq_instr", instr, 16'h3333);

        // PC wrap
        drive(0, 16'h0, 0, 1, 16'hFFFF, 0);
        chk("wrap_addr", imem_addr, 16'hFFFF);
        drive(1, 16'h4444, 0, 0, 16'h0, 0);
        chk("wrap_pc", instr_pc, 16'hFFFF);
        chk("wrap_pp1", pc_plus1, 16'h0000);
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        chk("wrap_next", imem_addr, 16'h0000);

        // Randomized traffic, checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0, rpc, 0);
        end

        // HALT: ignored under stall, taken on acceptance, absorbing
        goto_hold(16'hFFFF);
        drive(0, 16'h0, 1, 0, 16'h0, 1);
        chk("halt_stall_valid", instr_valid, 1);
        chk("halt_stall_halted", halted, 0);
        drive(0, 16'h0, 0, 0, 16'h0, 1);
        chk("halt_halted", halted, 1);
        chk("halt_req", imem_req, 0);
        chk("halt_valid", instr_valid, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'h1111, 0, 1, 16'h0080, 0);
            chk("halt_sticky", halted, 1);
            chk("halt_no_req", imem_req, 0);
        end

        // Reset between edges from HALTED
        #2 rst_n = 0;
        #1 chk_reset_vals("rst_halt");
        @(negedge clk);
        rst_n = 1;
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 16'h0000);
        drive(0, 16'h0, 0, 0, 16'h0, 0);

        // Reset in the high phase of a waiting request
        @(posedge clk);
        #3 rst_n = 0;
        #1 chk("midreq_req", imem_req, 0);
        chk("midreq_valid", instr_valid, 0);
        @(negedge clk);
        rst_n = 1;
        drive(0, 16'h0, 0, 0, 16'h0, 0);
        chk("midreq_restart_addr", imem_addr, 16'h0000);
        goto_hold(16'h7777);
        chk("midreq_pc", instr_pc, 16'h0000);
        chk("midreq_instr", instr, 16'h7777);
        drive(0, 16'h0, 0, 0, 16'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit WISC core. Holds the program counter, fetches one 16-bit instruction word at a time over a req/rdy handshake from the instruction memory or cache, and presents the word and its PC to the control decoder. It consumes the decoder's HALT indication and the resolved branch/call/return redirect, flushing the fetched word on redirect and freezing on halt.

## Interface
- ADDR_W, 16, PC and memory address width (word-addressed)
- RESET_PC, 16'h0000, first fetch address after reset

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_W  fetch word address, registered, stable while imem_req=1
- imem_rdy  in  1  memory completion; imem_data valid in the same cycle
- imem_data  in  16  fetched instruction word
- stall  in  1  downstream cannot accept the presented instruction this cycle
- redirect  in  1  one-cycle pulse: branch taken, CALL or RET resolved
- redirect_pc  in  ADDR_W  new fetch address, valid with redirect
- halt  in  1  decoder HALT for the currently presented instruction (16'hFFFF)
- instr  out  16  presented instruction
- instr_pc  out  ADDR_W  address of instr
- pc_plus1  out  ADDR_W  instr_pc+1 (CALL return address)
- instr_valid  out  1  instr/instr_pc/pc_plus1 valid
- halted  out  1  fetch permanently stopped until reset

## Operation
- States: IDLE, REQ, HOLD, HALTED. Reset → IDLE.
- IDLE: unconditionally → REQ; imem_addr=RESET_PC, imem_req=1 registered in the same transition.
- REQ: imem_req=1, imem_addr held. On imem_rdy: if no redirect pending, capture imem_data→instr, imem_addr→instr_pc, imem_addr+1→pc_plus1, instr_valid=1, → HOLD. If redirect pending (recorded during this REQ), discard data, clear pending, reissue to the recorded redirect_pc, stay in REQ.
- Redirect during REQ: latched into redirect_pending/pending_pc; imem_addr does not change until imem_rdy. A later redirect in the same REQ overwrites pending_pc. Redirect in the rdy cycle itself also discards the returning data.
- HOLD: instruction is accepted when instr_valid=1 and stall=0.
  - halt=1 on acceptance → HALTED: instr_valid=0, imem_req=0, halted=1.
  - else redirect=1 (stall ignored) → instr_valid=0, imem_addr=redirect_pc, → REQ.
  - else accepted → instr_valid=0, imem_addr=pc_plus1, → REQ.
  - else (stall=1) hold all outputs.
- Priority in HOLD: halt (when accepted) > redirect > normal advance. halt with stall=1 has no effect until stall drops.
- HALTED: absorbing; imem_req=0, instr_valid=0, halted=1; redirect and imem_rdy ignored. Only rst_n exits.
- PC arithmetic mod 2^ADDR_W: 16'hFFFF+1 = 16'h0000, no flag.
- At most one outstanding request; imem_rdy while imem_req=0 is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=16'h0000, instr_pc=0, pc_plus1=0, instr_valid=0, halted=0, pending cleared.
- Reset asserted mid-request abandons it immediately (imem_req drops asynchronously); no data captured.
- All outputs registered; no combinational path from inputs to outputs.
- First imem_req=1: cycle 1 after rst_n deassertion edge.
- Fetch latency: imem_rdy in cycle N → instr_valid=1 in N+1.
- Zero-wait memory, no stall: one instruction per 2 cycles (REQ, HOLD alternate).
- Redirect in HOLD: new imem_req address visible next cycle; flushed word never re-presented.

## Test plan
- Reset release, RESET_PC=0, imem_rdy tied high, imem_data=PC-valued words → instr_pc sequence 0,1,2,3 on alternate cycles, pc_plus1=instr_pc+1, req addr stable until rdy.
- Wait states: imem_rdy low 3 cycles at addr 5 → imem_addr=5 held 4 cycles, instr_valid rises cycle after rdy; stall=1 for 2 cycles in HOLD → outputs frozen, no new req.
- Redirect in HOLD to 16'h0040 with stall=1 → instr_valid drops next cycle, next fetch addr 16'h0040; redirect twice during REQ wait (0x10 then 0x20) → returned word discarded, next request to 0x20.
- HALT: present 16'hFFFF with halt=1, stall=0 → halted=1, imem_req=0 next cycle, stays so despite redirect; rst_n low → all outputs to reset values.
- Wrap: redirect_pc=16'hFFFF → presented instr_pc=16'hFFFF, pc_plus1=16'h0000, next fetch addr 16'h0000.
- Async reset asserted mid-REQ (between clock edges) → imem_req=0 immediately, restart from RESET_PC.
